ct_lsu_dcache_line_rd_seq: RTL and testbench

Initiator-side sequencer that reads one full cache line out of a 32-bit dcache data array and streams it as 16 word beats. It drives the array's active-low select, write-enable and index pins and accounts for the array's one-cycle read latency. Captured words are buffered so the downstream consumer (eviction or writeback buffer) can apply backpressure without losing data. It sits between the LSU victim/writeback logic and one data array instance, and shares that array with other masters through a per-cycle grant.

---
 rtl/ct_lsu_dcache_line_rd_seq_pkg.sv | 28 ++
 rtl/ct_lsu_dcache_rd_fifo.sv | 53 +++++
 rtl/ct_lsu_dcache_line_rd_seq.sv | 130 +++++++++++++
 tb/tb_ct_lsu_dcache_line_rd_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_lsu_dcache_line_rd_seq_pkg.sv
// Shared constants and types for the LSU dcache line read sequencer.
package ct_lsu_dcache_line_rd_seq_pkg;

    localparam int unsigned LINE_WORDS = 16;
    localparam int unsigned BUF_DEPTH  = 4;
    localparam int unsigned BUF_PTR_W  = 2;
    localparam int unsigned BUF_CNT_W  = 3;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned WEN_W      = 4;

    // Array pin levels when no access is being made (all active-low strobes high).
    localparam logic             SEL_B_IDLE  = 1'b1;
    localparam logic             GWEN_B_IDLE = 1'b1;
    localparam logic [WEN_W-1:0] WEN_B_IDLE  = 4'hf;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // One buffered beat: data word plus end-of-line marker.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

endpackage

// File: rtl/ct_lsu_dcache_rd_fifo.sv
// Small beat buffer between the array read port and the line consumer.
module ct_lsu_dcache_rd_fifo
    import ct_lsu_dcache_line_rd_seq_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  beat_t                push_beat,
    input  logic                 pop,
    output beat_t                head,
    output logic [BUF_CNT_W-1:0] count,
    output logic                 empty,
    output logic                 full
);

    beat_t                mem [BUF_DEPTH];
    logic [BUF_PTR_W-1:0] wr_ptr;
    logic [BUF_PTR_W-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (count == '0);
    assign full    = (count == BUF_CNT_W'(BUF_DEPTH));
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; reset clears entries so the head reads zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem[BUF_PTR_W'(i)] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_beat;
                wr_ptr      <= wr_ptr + BUF_PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + BUF_PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + BUF_CNT_W'(1);
                2'b01:   count <= count - BUF_CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ct_lsu_dcache_line_rd_seq.sv
// Reads one 16-word line from the shared dcache data array and streams it as beats.
module ct_lsu_dcache_line_rd_seq
    import ct_lsu_dcache_line_rd_seq_pkg::*;
#(
    parameter int unsigned IDX_W  = 11,
    parameter int unsigned WORD_W = 4,
    parameter int unsigned SET_W  = IDX_W - WORD_W
)
(
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic              req_vld,
    input  logic [SET_W-1:0]  req_set,
    output logic              req_rdy,
    input  logic              arb_grant,
    output logic              data_gateclk_en,
    output logic              data_sel_b,
    output logic              data_gwen_b,
    output logic [3:0]        data_wen_b,
    output logic [IDX_W-1:0]  data_idx,
    input  logic [31:0]       data_dout,
    output logic              beat_vld,
    output logic [31:0]       beat_data,
    output logic              beat_last,
    input  logic              beat_rdy,
    output logic              busy
);

    seq_state_e           state_q;
    seq_state_e           state_d;
    logic [SET_W-1:0]     set_q;
    logic [WORD_W-1:0]    issue_cnt_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 inflight_q;
    logic                 inflight_last_q;

    logic                 accept;
    logic                 issue;
    logic                 word_last;
    logic                 credit_ok;
    logic                 pop;
    beat_t                push_beat;
    beat_t                head;
    logic [BUF_CNT_W-1:0] buf_count;
    logic                 buf_empty;
    logic                 buf_full;

    assign req_rdy     = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign accept      = req_vld && req_rdy;
    assign word_last   = (issue_cnt_q == WORD_W'(LINE_WORDS - 1));
    // The read in flight already owns a buffer slot; a same-cycle pop is not credited.
    assign credit_ok   = ((buf_count + BUF_CNT_W'(inflight_q)) < BUF_CNT_W'(BUF_DEPTH))
                         && !buf_full;
    assign pop         = beat_vld && beat_rdy;
    assign data_gwen_b = GWEN_B_IDLE;
    assign data_wen_b  = WEN_B_IDLE;
    assign beat_vld    = !buf_empty;
    assign beat_data   = head.data;
    assign beat_last   = head.last;

    // Next state and array pin drive; reads are suppressed in the reset cycle.
    always_comb begin
        state_d         = state_q;
        issue           = 1'b0;
        data_sel_b      = SEL_B_IDLE;
        data_gateclk_en = 1'b0;
        data_idx        = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                issue = arb_grant && credit_ok && !cpurst;
                if (issue) begin
                    data_sel_b      = ~SEL_B_IDLE;
                    data_gateclk_en = 1'b1;
                    data_idx        = {set_q, issue_cnt_q};
                    if (word_last) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pop && head.last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Line address latch, issue counter, held index and inflight tracking.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            set_q           <= '0;
            issue_cnt_q     <= '0;
            idx_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            if (accept) begin
                set_q       <= req_set;
                issue_cnt_q <= '0;
            end else if (issue) begin
                issue_cnt_q <= issue_cnt_q + WORD_W'(1);
            end
            if (issue) idx_q <= data_idx;
            inflight_q      <= issue;
            inflight_last_q <= issue && word_last;
        end
    end

    assign push_beat = '{last: inflight_last_q, data: data_dout};

    ct_lsu_dcache_rd_fifo u_rd_fifo (
        .clk       (forever_cpuclk),
        .rst       (cpurst),
        .push      (inflight_q),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .count     (buf_count),
        .empty     (buf_empty),
        .full      (buf_full)
    );

endmodule

// File: tb/tb_ct_lsu_dcache_line_rd_seq.sv
// Directed bench for the dcache line read sequencer with a behavioural array model.
module tb_ct_lsu_dcache_line_rd_seq;

    logic        forever_cpuclk = 1'b0;
    logic        cpurst;
    logic        req_vld;
    logic [6:0]  req_set;
    logic        req_rdy;
    logic        arb_grant;
    logic        data_gateclk_en;
    logic        data_sel_b;
    logic        data_gwen_b;
    logic [3:0]  data_wen_b;
    logic [10:0] data_idx;
    logic [31:0] data_dout = 32'hDEAD_BEEF;
    logic        beat_vld;
    logic [31:0] beat_data;
    logic        beat_last;
    logic        beat_rdy;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    int          sel_cyc [$];
    logic [10:0] sel_idx [$];
    logic [31:0] bt_data [$];
    logic        bt_last [$];
    int          bt_cyc  [$];

    ct_lsu_dcache_line_rd_seq dut (
        .forever_cpuclk  (forever_cpuclk),
        .cpurst          (cpurst),
        .req_vld         (req_vld),
        .req_set         (req_set),
        .req_rdy         (req_rdy),
        .arb_grant       (arb_grant),
        .data_gateclk_en (data_gateclk_en),
        .data_sel_b      (data_sel_b),
        .data_gwen_b     (data_gwen_b),
        .data_wen_b      (data_wen_b),
        .data_idx        (data_idx),
        .data_dout       (data_dout),
        .beat_vld        (beat_vld),
        .beat_data       (beat_data),
        .beat_last       (beat_last),
        .beat_rdy        (beat_rdy),
        .busy            (busy)
    );

    always #5 forever_cpuclk = ~forever_cpuclk;

    always @(posedge forever_cpuclk) cyc <= cyc + 1;

    // Array contents: set 5 holds 0xA500_0000 + word; other sets offset by set in bits 12+.
    function automatic logic [31:0] line_word(input logic [6:0] s, input logic [3:0] w);
        return 32'hA500_0000 + ((32'(s) - 32'd5) << 12) + 32'(w);
    endfunction

    // One-cycle read latency array; non-selected cycles return garbage.
    always @(posedge forever_cpuclk)
        data_dout <= data_sel_b ? 32'hDEAD_BEEF : line_word(data_idx[10:4], data_idx[3:0]);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Per-cycle pin checks and capture of selects and accepted beats.
    always @(negedge forever_cpuclk) begin
        chk("gwen", 32'(data_gwen_b), 32'd1);
        chk("wen", 32'(data_wen_b), 32'hf);
        chk("gateclk", 32'(data_gateclk_en), 32'(!data_sel_b));
        if (!cpurst) begin
            if (!data_sel_b) begin
                chk("sel_grant", 32'(arb_grant), 32'd1);
                sel_cyc.push_back(cyc);
                sel_idx.push_back(data_idx);
            end
            if (beat_vld && beat_rdy) begin
                bt_data.push_back(beat_data);
                bt_last.push_back(beat_last);
                bt_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge forever_cpuclk);
        #1;
    endtask

    task automatic clear_q();
        sel_cyc.delete();
        sel_idx.delete();
        bt_data.delete();
        bt_last.delete();
        bt_cyc.delete();
    endtask

    task automatic wait_idle(input int budget, input bit tog, output int done);
        done = -1;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (tog) arb_grant = ~arb_grant;
            @(negedge forever_cpuclk);
            #1;
            if (req_rdy) begin
                done = cyc;
                break;
            end
        end
        chk("idle_reached", 32'(req_rdy), 32'd1);
    endtask

    task automatic check_line(input string nm, input logic [6:0] s);
        chk({nm, "_sel_count"}, 32'(sel_idx.size()), 32'd16);
        chk({nm, "_beat_count"}, 32'(bt_data.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < sel_idx.size())
                chk($sformatf("%s_idx[%0d]", nm, i), 32'(sel_idx[i]), 32'({s, 4'(i)}));
            if (i < bt_data.size()) begin
                chk($sformatf("%s_data[%0d]", nm, i), bt_data[i], line_word(s, 4'(i)));
                chk($sformatf("%s_last[%0d]", nm, i), 32'(bt_last[i]), 32'(i == 15));
            end
        end
    endtask

    int t0;
    int done;
    int a_last;

    initial begin
        cpurst    = 1'b1;
        req_vld   = 1'b0;
        req_set   = '0;
        arb_grant = 1'b1;
        beat_rdy  = 1'b1;
        repeat (3) tick();
        @(negedge forever_cpuclk);
        #1;
        chk("rst_req_rdy", 32'(req_rdy), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_beat_vld", 32'(beat_vld), 32'd0);
        chk("rst_beat_last", 32'(beat_last), 32'd0);
        chk("rst_beat_data", beat_data, 32'd0);
        chk("rst_sel_b", 32'(data_sel_b), 32'd1);
        chk("rst_gateclk", 32'(data_gateclk_en), 32'd0);
        chk("rst_idx", 32'(data_idx), 32'd0);
        tick();
        cpurst = 1'b0;
        tick();

        // Full-rate line read with exact cycle timing.
        clear_q();
        tick();
        req_vld = 1'b1;
        req_set = 7'h05;
        t0 = cyc;
        tick();
        req_vld = 1'b0;
        chk("t1_busy", 32'(busy), 32'd1);
        wait_idle(60, 1'b0, done);
        check_line("t1", 7'h05);
        for (int i = 0; i < 16; i++) begin
            if (i < sel_cyc.size())
                chk($sformatf("t1_sel_cyc[%0d]", i), 32'(sel_cyc[i]), 32'(t0 + 1 + i));
            if (i < bt_cyc.size())
                chk($sformatf("t1_beat_cyc[%0d]", i), 32'(bt_cyc[i]), 32'(t0 + 3 + i));
        end
        chk("t1_rdy_cyc", 32'(done), 32'(t0 + 19));

        // Consumer stalled: only four reads may be outstanding.
        clear_q();
        beat_rdy = 1'b0;
        tick();
        req_vld = 1'b1;
        req_set = 7'h12;
        tick();
        req_vld = 1'b0;
        repeat (10) tick();
        @(negedge forever_cpuclk);
        #1;
        chk("bp_sel_count", 32'(sel_idx.size()), 32'd4);
        chk("bp_sel_b_held", 32'(data_sel_b), 32'd1);
        chk("bp_beat_vld", 32'(beat_vld), 32'd1);
        chk("bp_busy", 32'(busy), 32'd1);
        tick();
        beat_rdy = 1'b1;
        wait_idle(80, 1'b0, done);
        check_line("bp", 7'h12);

        // Alternating grant: reads only in granted cycles, word 15 thirty cycles after word 0.
        clear_q();
        tick();
        req_vld = 1'b1;
        req_set = 7'h7F;
        tick();
        req_vld = 1'b0;
        wait_idle(100, 1'b1, done);
        arb_grant = 1'b1;
        check_line("tog", 7'h7F);
        if (sel_cyc.size() == 16)
            chk("tog_span", 32'(sel_cyc[15] - sel_cyc[0]), 32'd30);

        // Request held during a line must wait for the line's last beat.
        clear_q();
        tick();
        req_vld = 1'b1;
        req_set = 7'h00;
        tick();
        req_set = 7'h2A;
        wait_idle(60, 1'b0, done);
        check_line("hold_a", 7'h00);
        a_last = (bt_cyc.size() == 16) ? bt_cyc[15] : 0;
        clear_q();
        tick();
        req_vld = 1'b0;
        wait_idle(60, 1'b0, done);
        check_line("hold_b", 7'h2A);
        if (sel_cyc.size() > 0)
            chk("hold_b_start", 32'(sel_cyc[0]), 32'(a_last + 2));

        // Reset mid-line after word 6 is issued, then a clean re-read.
        clear_q();
        tick();
        req_vld = 1'b1;
        req_set = 7'h33;
        tick();
        req_vld = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge forever_cpuclk);
            #1;
            if (sel_idx.size() >= 7) break;
        end
        chk("mr_word6_issued", 32'(sel_idx.size()), 32'd7);
        tick();
        cpurst = 1'b1;
        tick();
        cpurst = 1'b0;
        @(negedge forever_cpuclk);
        #1;
        chk("mr_beat_vld", 32'(beat_vld), 32'd0);
        chk("mr_sel_b", 32'(data_sel_b), 32'd1);
        chk("mr_req_rdy", 32'(req_rdy), 32'd1);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_idx", 32'(data_idx), 32'd0);
        clear_q();
        tick();
        req_vld = 1'b1;
        req_set = 7'h33;
        tick();
        req_vld = 1'b0;
        wait_idle(60, 1'b0, done);
        check_line("mr", 7'h33);

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
